// File: rtl/dekatron_step_sequencer.sv
// dekatron_step_sequencer
// Front end of the dekatron pulse sender. A request is either a relative move
// of Steps positions or a move to an absolute BCD digit. The block issues one
// single-cycle PulseF/PulseR strobe per step, spaced PULSE_CYCLES+GUARD_CYCLES
// apart so the sender finishes each train. It also tracks the cathode position
// (0..9) and flags a wrap with a one-cycle Carry.
// Build option: define DEKATRON_SHORTEST_PATH_EN to make absolute (Set=1)
// moves take the shorter direction and ignore Dec. A tie at 5 goes forward.
// When the macro is undefined, Dec selects the direction for absolute moves too.
// Relative moves behave the same in both builds.
module dekatron_step_sequencer #(
   parameter int PULSE_CYCLES = 8,
   parameter int GUARD_CYCLES = 2,
   parameter int STEP_W       = 4
) (
   input  logic              i_hsClk,
   input  logic              i_Rst,
   input  logic              i_Request,
   input  logic              i_Dec,
   input  logic              i_Set,
   input  logic [STEP_W-1:0] i_Steps,
   input  logic [3:0]        i_Target,
   output logic              o_Ready,
   output logic              o_Busy,
   output logic              o_PulseF,
   output logic              o_PulseR,
   output logic [3:0]        o_Position,
   output logic              o_Carry
);

   // Step period. WAIT is loaded with T-2, so a strobe repeats every T cycles.
   localparam int T     = PULSE_CYCLES + GUARD_CYCLES;
   localparam int REM_W = (STEP_W > 4) ? STEP_W : 4;
   localparam int TMR_W = $clog2(T + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             r_state;
   logic               r_dec;
   logic [REM_W-1:0]   r_rem;
   logic [TMR_W-1:0]   r_timer;
   logic [3:0]         r_pos;
   logic               r_ready;
   logic               r_pulse_f;
   logic               r_pulse_r;
   logic               r_carry;

   logic [4:0]         w_fwd_wide;
   logic [4:0]         w_rev_wide;
   logic [3:0]         w_fwd_dist;
   logic [3:0]         w_rev_dist;
   logic               w_req_valid;
   logic               w_req_dec;
   logic [REM_W-1:0]   w_req_rem;

   // Decode the request: the step count, the direction, and whether the target is legal
   always_comb begin
      w_fwd_wide  = 5'd0;
      w_rev_wide  = 5'd0;
      w_req_valid = 1'b1;
      w_req_dec   = i_Dec;
      w_req_rem   = REM_W'(i_Steps);

      // Each distance is computed mod 10. The 5-bit form holds Target+10 without overflow.
      if (i_Target >= r_pos)
         w_fwd_wide = {1'b0, i_Target} - {1'b0, r_pos};
      else
         w_fwd_wide = {1'b0, i_Target} + 5'd10 - {1'b0, r_pos};
      if (r_pos >= i_Target)
         w_rev_wide = {1'b0, r_pos} - {1'b0, i_Target};
      else
         w_rev_wide = {1'b0, r_pos} + 5'd10 - {1'b0, i_Target};

      if (i_Set) begin
         w_req_valid = (i_Target <= 4'd9);
`ifdef DEKATRON_SHORTEST_PATH_EN
         w_req_dec = (w_fwd_wide[3:0] > 4'd5);
`else
         w_req_dec = i_Dec;
`endif
         w_req_rem = w_req_dec ? REM_W'(w_rev_wide[3:0]) : REM_W'(w_fwd_wide[3:0]);
      end
   end

   assign w_fwd_dist = w_fwd_wide[3:0];
   assign w_rev_dist = w_rev_wide[3:0];

   // Sequencer FSM: accept a request, then alternate ISSUE and WAIT until no steps remain
   always_ff @(posedge i_hsClk or posedge i_Rst) begin
      if (i_Rst) begin
         r_state   <= IDLE;
         r_dec     <= 1'b0;
         r_rem     <= '0;
         r_timer   <= '0;
         r_pos     <= 4'd0;
         r_ready   <= 1'b1;
         r_pulse_f <= 1'b0;
         r_pulse_r <= 1'b0;
         r_carry   <= 1'b0;
      end else begin
         // Strobes and Carry are single-cycle unless a state sets them again
         r_pulse_f <= 1'b0;
         r_pulse_r <= 1'b0;
         r_carry   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_Request && w_req_valid) begin
                  r_dec   <= w_req_dec;
                  r_rem   <= w_req_rem;
                  r_ready <= 1'b0;
                  if (w_req_rem != '0) begin
                     r_state   <= ISSUE;
                     r_pulse_f <= ~w_req_dec;
                     r_pulse_r <= w_req_dec;
                  end else begin
                     r_state <= DONE;
                  end
               end
            end
            ISSUE: begin
               // The strobe cycle ends here, so the new position shows one cycle after the strobe
               if (r_dec) begin
                  if (r_pos == 4'd0) begin
                     r_pos   <= 4'd9;
                     r_carry <= 1'b1;
                  end else begin
                     r_pos <= r_pos - 4'd1;
                  end
               end else begin
                  if (r_pos == 4'd9) begin
                     r_pos   <= 4'd0;
                     r_carry <= 1'b1;
                  end else begin
                     r_pos <= r_pos + 4'd1;
                  end
               end
               r_rem   <= r_rem - REM_W'(1);
               r_timer <= TMR_W'(T - 2);
               r_state <= WAIT;
            end
            WAIT: begin
               if (r_timer == '0) begin
                  if (r_rem != '0) begin
                     r_state   <= ISSUE;
                     r_pulse_f <= ~r_dec;
                     r_pulse_r <= r_dec;
                  end else begin
                     r_state <= IDLE;
                     r_ready <= 1'b1;
                  end
               end else begin
                  r_timer <= r_timer - TMR_W'(1);
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_ready <= 1'b1;
            end
            default: begin
               r_state <= IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign o_Ready    = r_ready;
   assign o_Busy     = ~r_ready;
   assign o_PulseF   = r_pulse_f;
   assign o_PulseR   = r_pulse_r;
   assign o_Position = r_pos;
   assign o_Carry    = r_carry;

   // The distances are also kept as named wires so they show up in waveform viewers
   logic w_unused;
   assign w_unused = ^{w_fwd_dist, w_rev_dist};

endmodule
